// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding
// and the add/subtract mode values.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_fa_cell.sv
// Combinational full adder built from two half-adder stages and an OR.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic cout,
  output logic sum
);

  logic h1_sum;
  logic h1_carry;
  logic h2_carry;

  // First half adder: x + y
  assign h1_sum   = x ^ y;
  assign h1_carry = x & y;

  // Second half adder: partial sum + carry in
  assign sum      = h1_sum ^ cin;
  assign h2_carry = h1_sum & cin;

  assign cout     = h1_carry | h2_carry;

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop,
// one bit per clock, LSB first, with start/busy/done handshake.
//
//   state   | meaning
//   --------+------------------------------------------------
//   IDLE    | waiting for start; result flags held
//   RUN     | one bit processed per edge, busy=1
//   DONE    | one-cycle done pulse, then back to IDLE
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             fa_s;
  logic             fa_c;

  fa_cell u_fa (
    .x    (sa[0]),
    .y    (sb[0]),
    .cin  (cy),
    .cout (fa_c),
    .sum  (fa_s)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Status outputs decode directly from the state register
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start outside IDLE is dropped, not queued
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, serial shift datapath and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa  <= a;
            // Subtract as A + ~B + 1: invert B and force the carry in
            sb  <= b ^ {WIDTH{sub}};
            cy  <= (sub == MODE_SUB) ? 1'b1 : cin;
            cnt <= '0;
          end
        end
        ST_RUN: begin
          sum <= {fa_s, sum[WIDTH-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cy  <= fa_c;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            // cy here is the carry into the MSB
            cout     <= fa_c;
            overflow <= cy ^ fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub at WIDTH=8.
module tb_serial_add_sub;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       overflow;

  int checks;
  int errors;

  serial_add_sub #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, scramble inputs while it runs, then check
  // timing and results. Inputs change on negedges, outputs sampled there too.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic ts, input logic tc, input logic [7:0] esum,
                        input logic ecout, input logic eovf, input logic [7:0] prev_sum);
    int busy_cnt;
    int done_idx;
    @(negedge clk);
    a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
    check({tag, "_sum_held"}, {24'd0, sum}, {24'd0, prev_sum});
    busy_cnt = 1;
    done_idx = -1;
    for (int i = 2; i <= 30; i++) begin
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      @(negedge clk);
      if (done) begin
        done_idx = i;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({tag, "_busy_cycles"}, busy_cnt, 32'd8);
    check({tag, "_done_idx"}, done_idx, 32'd9);
    check({tag, "_sum"}, {24'd0, sum}, {24'd0, esum});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eovf});
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_sum_after"}, {24'd0, sum}, {24'd0, esum});
  endtask

  initial begin
    int first_busy;
    int second_busy;
    int done_seen;
    logic done_flag;

    checks = 0;
    errors = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;

    // Reset then idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_sum", {24'd0, sum}, 32'd0);
      check("idle_cout", {31'd0, cout}, 32'd0);
      check("idle_ovf", {31'd0, overflow}, 32'd0);
    end

    // Arithmetic vectors
    run_op("add_cin", 8'h3C, 8'h55, 1'b0, 1'b1, 8'h92, 1'b0, 1'b1, 8'h00);
    run_op("wrap_add", 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h92);
    run_op("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8'h00);
    run_op("sub_borrow", 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 8'h80);
    run_op("sub_ovf", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 8'hFE);
    run_op("zero_m1", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h7F);

    // Handshake abuse: start held high, operands scrambled during RUN
    @(negedge clk);
    a = 8'h11; b = 8'h22; sub = 1'b0; cin = 1'b0; start = 1'b1;
    first_busy = -1; second_busy = -1; done_seen = 0; done_flag = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy && first_busy < 0) first_busy = i;
      if (done && done_seen == 0) begin
        done_seen = i;
        check("hold_sum1", {24'd0, sum}, 32'h33);
        a = 8'h40; b = 8'h02; sub = 1'b0; cin = 1'b0;
      end else if (done_seen != 0 && i == done_seen + 1) begin
        // start was high on the DONE edge; it must not have started an op
        check("hold_done_drop", {31'd0, busy}, 32'd0);
      end else if (busy && done_seen != 0 && second_busy < 0) begin
        second_busy = i;
        start = 1'b0;
      end else if (busy) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
      if (done && second_busy > 0) begin
        done_flag = 1'b1;
        check("hold_sum2", {24'd0, sum}, 32'h42);
        break;
      end
    end
    start = 1'b0;
    check("hold_period", second_busy - first_busy, 32'd10);
    check("hold_second_done", {31'd0, done_flag}, 32'd1);

    // Reset mid-operation
    @(negedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h33; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy_rst", {31'd0, busy}, 32'd0);
    check("mid_sum_rst", {24'd0, sum}, 32'd0);
    done_flag = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) done_flag = 1'b1;
    end
    check("mid_no_done", {31'd0, done_flag}, 32'd0);
    rst_n = 1'b1;
    run_op("post_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop process one bit per clock, LSB first.
- Start/busy/done handshake; result, carry-out and signed overflow are held until the next operation.
- Small-area arithmetic building block for datapaths where latency is cheap and gates are not; successor to the combinational full-adder cells.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- sub  in  1  0 = A+B+cin, 1 = A-B (cin ignored); captured with operands.
- cin  in  1  carry-in for add mode; captured with operands.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse when the result is final.
- sum  out  WIDTH  result; valid from the done cycle until the next accepted start.
- cout  out  1  carry-out of bit WIDTH-1 (subtract: 1 = no borrow).
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; busy, done, cout, overflow = 0; sum = 0; internal shift registers, carry and counter = 0.
  - Reset takes effect immediately, including mid-operation; the operation in progress is discarded with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge k: load A into shift register sa.
  - Load B^{WIDTH{sub}} into sb.
  - Carry flop = sub ? 1 : cin.
  - Counter = 0; state goes to RUN.
  - sum, cout and overflow keep their previous values until the first RUN edge.
- RUN (busy=1): at each edge, full-adder cell computes s,c from sa[0], sb[0] and the carry flop.
  - sum shifts right with s entering at bit WIDTH-1.
  - sa and sb shift right; carry flop = c; counter++.
  - On the edge where counter==WIDTH-1:
    - Capture the carry flop value (carry into MSB) for overflow.
    - cout = c; overflow = carry_into_msb ^ c.
    - State goes to DONE.
- Latency: busy is high for exactly WIDTH cycles, after edges k+1..k+WIDTH-1 and k+WIDTH-1... precisely:
  - busy=1 in the cycles following edges k through k+WIDTH-1.
  - done=1 in the single cycle following edge k+WIDTH.
  - Start-to-done = WIDTH+1 edges.
- DONE (done=1, busy=0): return to IDLE at the next edge unconditionally.
  - start asserted in DONE or RUN is ignored; it is not queued.
  - Back-to-back operations therefore have a minimum period of WIDTH+2 cycles.
- a, b, sub and cin may change freely after acceptance; they do not affect the operation in progress.
- Arithmetic rules:
  - sum = (A + B + cin) mod 2^WIDTH in add mode.
  - sum = (A - B) mod 2^WIDTH in subtract mode.
  - All outputs are registered; no combinational path from inputs to outputs.
- Wrap cases:
  - All-ones + 1 gives sum 0, cout 1.
  - 0 - 1 gives all-ones, cout 0.

Decomposition:
- Shared package serial_arith_pkg: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and an ADD/SUB mode constant.
- One sub-module, fa_cell: combinational full adder with ports x, y, cin, cout, sum, built from two half-adder stages plus an OR.
  - Instantiated once for the per-bit step.
- Everything else (FSM, counter, shift registers, flags) lives in the top module.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then high with start=0 for 10 cycles -> busy=done=0, sum=0x00, cout=overflow=0 throughout.
- Add with carry-in, WIDTH=8: a=0x3C, b=0x55, cin=1, sub=0, start pulse -> busy high 8 cycles; done pulse at edge 9; sum=0x92, cout=0, overflow=1.
- Wrap add: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, overflow=1.
- Subtract: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0 (borrow), overflow=0. Then a=0x80, b=0x01 -> sum=0x7F, cout=1, overflow=1.
- Handshake abuse: hold start=1 continuously and change a/b every cycle during RUN -> result matches operands captured at acceptance; a new op starts only after DONE→IDLE, period 10 cycles. Also check start during DONE is dropped.
- Reset mid-operation: rst_n low asynchronously (between edges) at cycle 4 of RUN -> busy and sum go to 0 immediately; no done pulse. A fresh op after release (a=0x01, b=0x01) -> sum=0x02.
